jt51_pm_sched: RTL and testbench
================================

// Module: jt51_pm_sched
// PURPOSE
//  Time-multiplexes one jt51_pm pitch-modulation datapath across all FM channels.
//  - Holds per-channel KC/KF/PMS and scales the shared LFO PM value by each channel's PMS.
//  - Once per sample sweep, drives the datapath for each channel in turn.
//  - Captures the resulting KCEX values into a table read by the phase generator.
//  - Sits between the register interface/LFO and the phase-generator front end.
// PARAMETERS
//  NCH  8  number of channels swept. Legal range 2..8. Channel index is always 3 bits.
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  cen        in   1   clock enable; all state advances only when cen=1
//  start      in   1   request a new sweep; single-cycle pulse qualified by cen
//  lfo_pm     in   8   LFO PM value, two's complement, -128..+127
//  cfg_we     in   1   write channel config (qualified by cen)
//  cfg_ch     in   3   channel being written
//  cfg_kc     in   7   key code
//  cfg_kf     in   6   key fraction
//  cfg_pms    in   3   PM sensitivity
//  pm_kc      out  7   to datapath kc_I
//  pm_kf      out  6   to datapath kf_I
//  pm_mod     out  9   to datapath mod_I
//  pm_add     out  1   to datapath add
//  pm_kcex    in   13  from datapath kcex (combinational from pm_* outputs)
//  rd_ch      in   3   table read address
//  rd_kcex    out  13  table read data, combinational from rd_ch
//  busy       out  1   sweep in progress
//  done       out  1   one-cen-cycle pulse when the last result is written
// BEHAVIOUR
//  Reset values (asynchronous, on rst_n=0):
//  - All config registers, the KCEX table and all pm_* outputs are 0.
//  - busy=0, done=0, pending=0. State is IDLE.
//  LFO magnitude and sign:
//  - mag = |lfo_pm|, clamped to 127. sgn = lfo_pm[7].
//  PMS scaling (mod, 9 bits zero-extended):
//  - pms 0 -> 0
//  - pms 1..5 -> mag>>5, >>4, >>3, >>2, >>1
//  - pms 6 -> mag
//  - pms 7 -> mag<<1
//  - pm_add = ~sgn. When mod=0, pm_add=1.
//  State machine: IDLE, RUN, FLUSH.
//  - IDLE: on start, latch lfo_pm into lfo_r, set iss=0, enter RUN, set busy=1.
//    lfo_r is held for the whole sweep.
//  - RUN: each cen cycle, drive pm_* from channel iss config and lfo_r, and register cap=iss.
//    On the next cen cycle, write pm_kcex into table[cap].
//    iss increments each cycle. After issuing iss=NCH-1, enter FLUSH.
//  - FLUSH: write the last result, pulse done, clear busy, return to IDLE.
//  - If pending=1 on leaving FLUSH, go straight to RUN instead of IDLE.
//    This latches a fresh lfo_r and clears pending; busy stays 1.
//  Latency: a sweep takes NCH+1 cen cycles from the start cycle to done.
//  - Channel n's result is visible on rd_kcex n+2 cen cycles after start.
//  - Write-enable and pm_* outputs are held while cen=0.
//  Start handling:
//  - start while busy sets pending (one deep). Further starts while pending=1 are dropped.
//  - start on the cycle done pulses counts as busy, so it sets pending.
//  Config writes:
//  - Take effect on the next cen cycle and are accepted at any time.
//  - A write to the channel being issued in the same cycle does not affect that issue (old value used).
//  - Channels already issued keep stale results until the next sweep.
//  Unsupported inputs:
//  - cfg_ch >= NCH: the write is ignored.
//  - rd_ch >= NCH: rd_kcex returns 0.
//  pm_* hold their last issued values in IDLE.
//  Reset mid-sweep: everything returns to reset values immediately; no done pulse.
// TESTING
//  T1 Reset, then read all channels -> rd_kcex=0, busy=0, done=0.
//  T2 ch3 kc=7'h12 kf=0 pms=0, start, lfo_pm=+100 -> rd_kcex[3]=13'h0480; done exactly 9 cen cycles after start.
//  T3 ch0 kc=7'h10 kf=0 pms=6, lfo_pm=+32, start -> pm_mod=32, pm_add=1, table[0]=13'h0420.
//     Repeat with lfo_pm=-32 -> pm_add=0, table[0]=13'h03A0.
//  T4 Two starts during one sweep -> exactly one extra sweep, busy stays high across both, two done pulses.
//     The second sweep uses lfo_pm sampled at its own launch.
//  T5 cfg write to ch2 pms 0->7 in the same cycle ch2 is issued -> that sweep uses pms 0; the next sweep uses pms 7.
//  T6 rst_n low mid-sweep (iss=4) with cen toggling -> all outputs 0 asynchronously, no done.
//     After release, start runs a clean full sweep.

Source files
------------

// File: rtl/jt51_pm_sched.sv
// Sweeps one shared jt51_pm pitch-modulation datapath across all channels once per
// sample and keeps the resulting KCEX values in a table for the phase generator.
module jt51_pm_sched #(
    parameter int unsigned NCH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        start,
    input  logic [7:0]  lfo_pm,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_ch,
    input  logic [6:0]  cfg_kc,
    input  logic [5:0]  cfg_kf,
    input  logic [2:0]  cfg_pms,
    output logic [6:0]  pm_kc,
    output logic [5:0]  pm_kf,
    output logic [8:0]  pm_mod,
    output logic        pm_add,
    input  logic [12:0] pm_kcex,
    input  logic [2:0]  rd_ch,
    output logic [12:0] rd_kcex,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TBL_DEPTH = 8;
    localparam int unsigned MAG_W     = 7;
    localparam int unsigned MOD_W     = 9;
    localparam int unsigned KCEX_W    = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         iss;
    logic [2:0]         cap;
    logic               wr_en;
    logic               pending;
    logic [7:0]         lfo_r;

    logic [6:0]         cfg_kc_r  [0:TBL_DEPTH-1];
    logic [5:0]         cfg_kf_r  [0:TBL_DEPTH-1];
    logic [2:0]         cfg_pms_r [0:TBL_DEPTH-1];
    logic [KCEX_W-1:0]  tbl       [0:TBL_DEPTH-1];

    logic [MAG_W-1:0]   mag_c;
    logic [MOD_W-1:0]   mod_c;
    logic               add_c;
    logic [2:0]         iss_pms_c;
    logic               cfg_ok_c;

    assign iss_pms_c = cfg_pms_r[iss];
    assign cfg_ok_c  = cfg_we && (32'(cfg_ch) < NCH);

    // |lfo_r| clamped to 127, then scaled by the PMS of the channel being issued
    always_comb begin
        mag_c = lfo_r[6:0];
        if (lfo_r[7]) begin
            mag_c = (lfo_r[6:0] == 7'd0) ? 7'h7f : 7'(~lfo_r[6:0] + 7'd1);
        end
        mod_c = '0;
        case (iss_pms_c)
            3'd0:    mod_c = '0;
            3'd1:    mod_c = MOD_W'(mag_c >> 5);
            3'd2:    mod_c = MOD_W'(mag_c >> 4);
            3'd3:    mod_c = MOD_W'(mag_c >> 3);
            3'd4:    mod_c = MOD_W'(mag_c >> 2);
            3'd5:    mod_c = MOD_W'(mag_c >> 1);
            3'd6:    mod_c = MOD_W'(mag_c);
            default: mod_c = {1'b0, mag_c, 1'b0};
        endcase
        add_c = (mod_c == '0) || !lfo_r[7];
    end

    assign rd_kcex = (32'(rd_ch) < NCH) ? tbl[rd_ch] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            iss     <= '0;
            cap     <= '0;
            wr_en   <= 1'b0;
            pending <= 1'b0;
            lfo_r   <= '0;
            pm_kc   <= '0;
            pm_kf   <= '0;
            pm_mod  <= '0;
            pm_add  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < TBL_DEPTH; i++) begin
                cfg_kc_r[i]  <= '0;
                cfg_kf_r[i]  <= '0;
                cfg_pms_r[i] <= '0;
                tbl[i]       <= '0;
            end
        end else if (cen) begin
            done  <= 1'b0;
            wr_en <= 1'b0;
            if (cfg_ok_c) begin
                cfg_kc_r[cfg_ch]  <= cfg_kc;
                cfg_kf_r[cfg_ch]  <= cfg_kf;
                cfg_pms_r[cfg_ch] <= cfg_pms;
            end
            // result of the previous issue is on pm_kcex now
            if (wr_en) begin
                tbl[cap] <= pm_kcex;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        lfo_r <= lfo_pm;
                        iss   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    pm_kc  <= cfg_kc_r[iss];
                    pm_kf  <= cfg_kf_r[iss];
                    pm_mod <= mod_c;
                    pm_add <= add_c;
                    cap    <= iss;
                    wr_en  <= 1'b1;
                    if (start) begin
                        pending <= 1'b1;
                    end
                    if (32'(iss) == NCH - 1) begin
                        state <= FLUSH;
                    end else begin
                        iss <= iss + 3'd1;
                    end
                end
                FLUSH: begin
                    done <= 1'b1;
                    // a start arriving now is treated as a queued request
                    if (pending || start) begin
                        lfo_r   <= lfo_pm;
                        iss     <= '0;
                        pending <= 1'b0;
                        state   <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt51_pm_sched.sv
// Bench for jt51_pm_sched: sweep-level reference model, jt51-like datapath stand-in,
// directed scenarios and a randomized run.
module tb_jt51_pm_sched;

    localparam int unsigned NCH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  lfo_pm = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [6:0]  cfg_kc = '0;
    logic [5:0]  cfg_kf = '0;
    logic [2:0]  cfg_pms = '0;
    logic [6:0]  pm_kc;
    logic [5:0]  pm_kf;
    logic [8:0]  pm_mod;
    logic        pm_add;
    logic [12:0] pm_kcex;
    logic [2:0]  rd_ch = '0;
    logic [12:0] rd_kcex;
    logic        busy;
    logic        done;

    jt51_pm_sched #(.NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .lfo_pm(lfo_pm),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_kc(cfg_kc), .cfg_kf(cfg_kf), .cfg_pms(cfg_pms),
        .pm_kc(pm_kc), .pm_kf(pm_kf), .pm_mod(pm_mod), .pm_add(pm_add), .pm_kcex(pm_kcex),
        .rd_ch(rd_ch), .rd_kcex(rd_kcex), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath stand-in: linear semitone arithmetic with the jt51 "skip every 4th code" mapping
    function automatic logic [12:0] dp(input logic [6:0] kc, input logic [5:0] kf,
                                       input logic [8:0] md, input logic add);
        int oct, nt, idx, lin, code;
        oct = int'(kc[6:4]);
        nt  = int'(kc[3:0]);
        idx = nt - nt / 4;
        lin = (oct * 12 + idx) * 64 + int'(kf);
        lin = add ? lin + int'(md) : lin - int'(md);
        if (lin < 0) lin = 0;
        if (lin > 6143) lin = 6143;
        oct  = lin / 768;
        idx  = (lin % 768) / 64;
        code = idx + idx / 3;
        return 13'(oct * 1024 + code * 64 + lin % 64);
    endfunction

    function automatic int mod_of(input int pms, input logic [7:0] lfo);
        int mag;
        mag = lfo[7] ? 256 - int'(lfo) : int'(lfo);
        if (mag > 127) mag = 127;
        if (pms == 0) return 0;
        if (pms == 7) return mag * 2;
        return mag >> (6 - pms);
    endfunction

    always_comb pm_kcex = dp(pm_kc, pm_kf, pm_mod, pm_add);

    // Reference model: a sweep is a phase count since launch
    logic [6:0]  m_kc  [0:7];
    logic [5:0]  m_kf  [0:7];
    int          m_pms [0:7];
    logic [12:0] m_tbl [0:7];
    bit          m_active, m_pend, m_done;
    int          m_p;
    logic [7:0]  m_lfo;
    logic [6:0]  e_kc;
    logic [5:0]  e_kf;
    logic [8:0]  e_mod;
    logic        e_add;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_kc[i] = '0; m_kf[i] = '0; m_pms[i] = 0; m_tbl[i] = '0;
        end
        m_active = 0; m_pend = 0; m_done = 0; m_p = 0; m_lfo = '0;
        e_kc = '0; e_kf = '0; e_mod = '0; e_add = 1'b0;
    endtask

    task automatic model_step();
        if (!cen) return;
        m_done = 0;
        if (m_active) begin
            if (m_p >= 1) m_tbl[m_p-1] = dp(e_kc, e_kf, e_mod, e_add);
            if (m_p < int'(NCH)) begin
                e_kc  = m_kc[m_p];
                e_kf  = m_kf[m_p];
                e_mod = 9'(mod_of(m_pms[m_p], m_lfo));
                e_add = (e_mod == 9'd0) || !m_lfo[7];
            end
            if (m_p == int'(NCH)) begin
                m_done = 1;
                if (m_pend || start) begin
                    m_lfo = lfo_pm; m_p = 0; m_pend = 0;
                end else begin
                    m_active = 0;
                end
            end else begin
                if (start) m_pend = 1;
                m_p++;
            end
        end else if (start) begin
            m_active = 1; m_p = 0; m_lfo = lfo_pm;
        end
        if (cfg_we && int'(cfg_ch) < int'(NCH)) begin
            m_kc[cfg_ch] = cfg_kc; m_kf[cfg_ch] = cfg_kf; m_pms[cfg_ch] = int'(cfg_pms);
        end
    endtask

    // One clock: model follows the DUT on the edge, then single-cycle pulses drop
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #2;
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy",    int'(busy),    int'(m_active));
            chk("done",    int'(done),    int'(m_done));
            chk("pm_kc",   int'(pm_kc),   int'(e_kc));
            chk("pm_kf",   int'(pm_kf),   int'(e_kf));
            chk("pm_mod",  int'(pm_mod),  int'(e_mod));
            chk("pm_add",  int'(pm_add),  int'(e_add));
            chk("rd_kcex", int'(rd_kcex), int'(m_tbl[rd_ch]));
        end
    end

    task automatic cfg_write(input int ch, input int kc, input int kf, input int pms);
        cen = 1'b1; cfg_we = 1'b1;
        cfg_ch = 3'(ch); cfg_kc = 7'(kc); cfg_kf = 6'(kf); cfg_pms = 3'(pms);
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, int'(busy), 0);
    endtask

    task automatic read_chk(input string tag, input int ch, input int exp);
        rd_ch = 3'(ch);
        #1;
        chk(tag, int'(rd_kcex), exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dones;
        model_reset();
        #1 chk_on = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;

        // T1: reset contents
        for (int ch = 0; ch < 8; ch++) begin
            read_chk("t1_rd", ch, 0);
            tick();
        end
        chk("t1_busy", int'(busy), 0);
        chk("t1_done", int'(done), 0);

        // T2: pms 0 leaves kc/kf untouched; done latency
        cfg_write(3, 'h12, 0, 0);
        lfo_pm = 8'd100; start = 1'b1; tick();
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        chk("t2_latency", n, 9);
        read_chk("t2_kcex", 3, 'h0480);
        tick();

        // T3: positive and negative LFO on pms 6
        cfg_write(0, 'h10, 0, 6);
        lfo_pm = 8'd32; start = 1'b1; tick();
        tick();
        #1;
        chk("t3_mod_pos", int'(pm_mod), 32);
        chk("t3_add_pos", int'(pm_add), 1);
        wait_idle("t3_idle_pos");
        read_chk("t3_kcex_pos", 0, 'h0420);
        lfo_pm = 8'hE0; start = 1'b1; tick();
        tick();
        #1;
        chk("t3_mod_neg", int'(pm_mod), 32);
        chk("t3_add_neg", int'(pm_add), 0);
        wait_idle("t3_idle_neg");
        read_chk("t3_kcex_neg", 0, 'h03A0);
        tick();

        // T4: two starts mid-sweep give one extra sweep with its own LFO sample
        lfo_pm = 8'd32; start = 1'b1; tick();
        dones = 0;
        for (int i = 1; i <= 30; i++) begin
            start  = (i == 2 || i == 4);
            lfo_pm = (i >= 9) ? 8'hE0 : 8'd32;
            tick();
            if (done) dones++;
            if (i <= 17) chk("t4_busy", int'(busy), 1);
        end
        chk("t4_dones", dones, 2);
        read_chk("t4_kcex", 0, 'h03A0);

        // T5: config write coinciding with the channel's issue
        cfg_write(2, 'h20, 0, 0);
        lfo_pm = 8'd64; start = 1'b1; tick();
        tick(); tick();
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_kc = 7'h20; cfg_kf = '0; cfg_pms = 3'd7;
        tick();
        wait_idle("t5_idle_a");
        read_chk("t5_old_pms", 2, 'h0800);
        tick();
        start = 1'b1; tick();
        wait_idle("t5_idle_b");
        read_chk("t5_new_pms", 2, 'h0880);
        tick();

        // T6: asynchronous reset mid-sweep
        start = 1'b1; tick();
        for (int i = 0; i < 8; i++) begin
            cen = (i % 2 == 1);
            tick();
        end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_pm_kc", int'(pm_kc), 0);
        chk("t6_pm_mod", int'(pm_mod), 0);
        chk("t6_pm_add", int'(pm_add), 0);
        read_chk("t6_tbl", 2, 0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            cen = (i % 2 == 0);
            tick();
            if (done) dones++;
        end
        chk("t6_no_done", dones, 0);
        rst_n = 1'b1;
        cfg_write(3, 'h12, 0, 0);
        lfo_pm = 8'd100; start = 1'b1; tick();
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        chk("t6_latency", n, 9);
        read_chk("t6_kcex", 3, 'h0480);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cen     = ($urandom % 4) != 0;
            start   = ($urandom % 12) == 0;
            cfg_we  = ($urandom % 3) == 0;
            cfg_ch  = 3'($urandom);
            cfg_kc  = 7'($urandom);
            cfg_kf  = 6'($urandom);
            cfg_pms = 3'($urandom);
            lfo_pm  = 8'($urandom);
            rd_ch   = 3'($urandom);
            if (($urandom % 700) == 0) begin
                #1 rst_n = 1'b0;
                model_reset();
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
